serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial N-bit adder: the addition counterpart of the team's half subtractor, built around a single full-adder cell and a carry flip-flop.
- Operands are captured on a start strobe and processed LSB-first, one bit per clock. The block returns the sum and carry-out with a done pulse.
- Used as a low-area arithmetic unit in the team's small datapath blocks, where throughput is not critical.

Parameters:
- WIDTH, 8, operand and sum width in bits (must be >= 1).
- CW, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  augend; captured on accepted start.
- b  input  WIDTH  addend; captured on accepted start.
- busy  output  1  high while an addition is in progress (RUN state).
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  result a+b mod 2^WIDTH; held until next accepted start.
- cout  output  1  carry out of the MSB; held with sum.

Behaviour:
- Reset: asynchronous on rst_n low, released synchronously by design use. All state is cleared: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, count=0, operand registers=0.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If start=1 at an edge: latch a into A_r and b into B_r, carry<=0, count<=0, state<=RUN.
  - busy is 1 from the following cycle.
  - sum and cout keep their previous values until overwritten bit by bit.
- RUN, each edge:
  - s = A_r[0] ^ B_r[0] ^ carry.
  - carry <= (A_r[0] & B_r[0]) | (carry & (A_r[0] ^ B_r[0])).
  - A_r and B_r shift right by 1.
  - sum <= {s, sum[WIDTH-1:1]}: result enters at the MSB and reaches its correct position after WIDTH shifts.
  - count <= count+1.
  - On the edge where count==WIDTH-1: state<=DONE, cout<=new carry, done<=1, busy<=0.
- DONE: lasts exactly one cycle, then state<=IDLE and done<=0.
- Latency: start accepted at edge k -> done=1 in the cycle after edge k+WIDTH, with sum/cout valid in that same cycle. The next start can be accepted at edge k+WIDTH+2 at the earliest.
- Intermediate values: sum is not meaningful while busy=1. Consumers must qualify with done.
- start while busy=1 or in DONE: ignored; the operation in flight is unaffected and no request is queued.
- a and b changing after acceptance: no effect on the result.
- WIDTH=1: a single RUN cycle; done follows 1 cycle after acceptance.
- Reset mid-operation: immediate abort to the reset values above. No done pulse is produced and the partial sum is discarded.
- Overflow: wrap-around modulo 2^WIDTH; the carry is reported only on cout.

Test Plan:
- WIDTH=8: reset asserted -> busy=0, done=0, sum=8'h00, cout=0. After release with start=0 for 5 cycles -> outputs unchanged.
- a=8'h0F, b=8'h01, start pulse -> busy high 8 cycles. done pulses exactly 9 edges after the start edge with sum=8'h10, cout=0. sum holds 8'h10 afterwards.
- Carry chain: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1. Then a=8'hA5, b=8'h5A -> sum=8'hFF, cout=0.
- start with a=8'h03, b=8'h04, then start re-asserted every cycle with a=8'hFF, b=8'hFF while busy -> single done with sum=8'h07, cout=0. The next start is accepted only once IDLE is reached.
- Reset mid-op: start a=8'h80, b=8'h80, pull rst_n low at cycle 4 -> all outputs 0 asynchronously and no done pulse. A fresh start after release gives sum=8'h00, cout=1.
- Randomised sweep of 200 operand pairs against a reference model of a+b. Checks: {cout,sum} matches, exactly one done per accepted start, and busy and done never high together.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, operands consumed LSB-first.
// Latency: start accepted at edge k -> done/sum/cout valid in the cycle after edge k+WIDTH.
// Backpressure: none; start is only sampled in IDLE and is dropped (not queued) otherwise.
module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry;
    logic [CW-1:0]    count;

    logic             s;
    logic             carry_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] sum_shift;

    assign s         = a_r[0] ^ b_r[0] ^ carry;
    assign carry_nxt = (a_r[0] & b_r[0]) | (carry & (a_r[0] ^ b_r[0]));
    assign last_bit  = (count == CW'(WIDTH - 1));

    // New result bit enters at the MSB; after WIDTH shifts bit 0 has reached position 0.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_shift = s;
        end else begin : g_wn
            assign sum_shift = {s, sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    sum   <= sum_shift;
                    carry <= carry_nxt;
                    a_r   <= a_r >> 1;
                    b_r   <= b_r >> 1;
                    count <= count + CW'(1);
                    if (last_bit) begin
                        cout <= carry_nxt;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
